// File: rtl/noc_xbar_mem_scheduler.sv
// Round-robin scheduler sharing one 1rw synchronous memory among several requesters.
// Define NOC_XBAR_MEM_SCHED_WRITE_ACK_EN to return a response for writes as well as reads.
module noc_xbar_mem_scheduler #(
  parameter int req_ports_p  = 2,
  parameter int addr_width_p = 2,
  parameter int data_width_p = 32,
  parameter int id_width_p   = (req_ports_p > 1) ? $clog2(req_ports_p) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [req_ports_p-1:0]               req_v_i,
  input  logic [req_ports_p*addr_width_p-1:0]  req_addr_i,
  input  logic [req_ports_p*data_width_p-1:0]  req_data_i,
  input  logic [req_ports_p-1:0]               req_w_i,
  output logic [req_ports_p-1:0]               req_yumi_o,
  output logic                                 mem_v_o,
  output logic                                 mem_w_o,
  output logic [addr_width_p-1:0]              mem_addr_o,
  output logic [data_width_p-1:0]              mem_data_o,
  input  logic [data_width_p-1:0]              mem_data_i,
  output logic                                 resp_v_o,
  output logic [data_width_p-1:0]              resp_data_o,
  output logic [id_width_p-1:0]                resp_dest_id_o,
  input  logic                                 resp_yumi_i,
  output logic                                 busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_next_s;
  logic [id_width_p-1:0]     last_r;
  logic [id_width_p-1:0]     id_r;
  logic [data_width_p-1:0]   resp_data_r;

  logic                      hi_found_s;
  logic                      lo_found_s;
  logic [id_width_p-1:0]     hi_idx_s;
  logic [id_width_p-1:0]     lo_idx_s;
  logic                      gnt_found_s;
  logic [id_width_p-1:0]     gnt_idx_s;
  logic                      grant_s;
  logic                      sel_w_s;
  logic [addr_width_p-1:0]   sel_addr_s;
  logic [data_width_p-1:0]   sel_data_s;

  // Round-robin search: lowest valid port above last_r, otherwise lowest valid port overall.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    for (int i = req_ports_p - 1; i >= 0; i--) begin
      if (req_v_i[i]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = id_width_p'(i);
        if (i > int'(last_r)) begin
          hi_found_s = 1'b1;
          hi_idx_s   = id_width_p'(i);
        end else begin
          hi_found_s = hi_found_s;
        end
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    gnt_found_s = hi_found_s | lo_found_s;
    if (hi_found_s) begin
      gnt_idx_s = hi_idx_s;
    end else begin
      gnt_idx_s = lo_idx_s;
    end
  end

  // Field mux for the winning port.
  always_comb begin
    sel_w_s    = 1'b0;
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < req_ports_p; i++) begin
      if (gnt_idx_s == id_width_p'(i)) begin
        sel_w_s    = req_w_i[i];
        sel_addr_s = req_addr_i[i*addr_width_p +: addr_width_p];
        sel_data_s = req_data_i[i*data_width_p +: data_width_p];
      end else begin
        sel_w_s = sel_w_s;
      end
    end
  end

  // Grants only from IDLE and never while reset is asserted.
  assign grant_s = reset_n_i && (state_r == IDLE) && gnt_found_s;

  // Memory port and grant drive.
  always_comb begin
    req_yumi_o = '0;
    mem_v_o    = 1'b0;
    mem_w_o    = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (grant_s) begin
      req_yumi_o[gnt_idx_s] = 1'b1;
      mem_v_o               = 1'b1;
      mem_w_o               = sel_w_s;
      mem_addr_o            = sel_addr_s;
      mem_data_o            = sel_data_s;
    end else begin
      mem_v_o = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          if (!sel_w_s) begin
            state_next_s = READ;
          end else begin
`ifdef NOC_XBAR_MEM_SCHED_WRITE_ACK_EN
            state_next_s = RESP;
`else
            state_next_s = IDLE;
`endif
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      READ: state_next_s = RESP;
      RESP: begin
        if (resp_yumi_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Arbitration pointer and response id, updated on every grant.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_r <= id_width_p'(req_ports_p - 1);
      id_r   <= '0;
    end else if (grant_s) begin
      last_r <= gnt_idx_s;
      id_r   <= gnt_idx_s;
    end else begin
      last_r <= last_r;
      id_r   <= id_r;
    end
  end

  // Response data: read data one cycle after the grant, or the written data when acked.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_data_r <= '0;
    end else begin
      case (state_r)
        READ: resp_data_r <= mem_data_i;
`ifdef NOC_XBAR_MEM_SCHED_WRITE_ACK_EN
        IDLE: begin
          if (grant_s && sel_w_s) begin
            resp_data_r <= sel_data_s;
          end else begin
            resp_data_r <= resp_data_r;
          end
        end
`endif
        default: resp_data_r <= resp_data_r;
      endcase
    end
  end

  assign resp_v_o       = (state_r == RESP);
  assign resp_data_o    = resp_data_r;
  assign resp_dest_id_o = id_r;
  assign busy_o         = (state_r != IDLE);

endmodule

// File: tb/tb_noc_xbar_mem_scheduler.sv
// Directed bench for noc_xbar_mem_scheduler with a small behavioural 1rw memory.
module tb_noc_xbar_mem_scheduler;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [1:0]  req_v_i;
  logic [3:0]  req_addr_i;
  logic [63:0] req_data_i;
  logic [1:0]  req_w_i;
  logic [1:0]  req_yumi_o;
  logic        mem_v_o;
  logic        mem_w_o;
  logic [1:0]  mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        resp_v_o;
  logic [31:0] resp_data_o;
  logic [0:0]  resp_dest_id_o;
  logic        resp_yumi_i;
  logic        busy_o;

  logic [31:0] mem_r [4];
  int          errors = 0;
  int          checks = 0;

  noc_xbar_mem_scheduler dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .req_v_i        (req_v_i),
    .req_addr_i     (req_addr_i),
    .req_data_i     (req_data_i),
    .req_w_i        (req_w_i),
    .req_yumi_o     (req_yumi_o),
    .mem_v_o        (mem_v_o),
    .mem_w_o        (mem_w_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i),
    .resp_v_o       (resp_v_o),
    .resp_data_o    (resp_data_o),
    .resp_dest_id_o (resp_dest_id_o),
    .resp_yumi_i    (resp_yumi_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural single-port memory, one-cycle read latency.
  always @(posedge clk_i) begin
    if (mem_v_o && mem_w_o) mem_r[mem_addr_o] <= mem_data_o;
    if (mem_v_o && !mem_w_o) mem_data_i <= mem_r[mem_addr_o];
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    mem_r[0] = 32'h0;
    mem_r[1] = 32'h0;
    mem_r[2] = 32'hDEADBEEF;
    mem_r[3] = 32'h0;
    mem_data_i  = 32'h0;
    reset_n_i   = 1'b0;
    req_v_i     = 2'b00;
    req_addr_i  = 4'h0;
    req_data_i  = 64'h0;
    req_w_i     = 2'b00;
    resp_yumi_i = 1'b0;
    #2;
    check_val("rst_resp_v", resp_v_o, 1'b0);
    check_val("rst_busy", busy_o, 1'b0);
    check_val("rst_data", resp_data_o, 32'h0);
    req_v_i = 2'b11;
    #1;
    check_val("rst_yumi", req_yumi_o, 2'b00);
    check_val("rst_mem_v", mem_v_o, 1'b0);
    req_v_i = 2'b00;
    tick();
    tick();
    reset_n_i = 1'b1;
    tick();

    // Single read by port 0 of addr 2
    req_v_i = 2'b01; req_w_i = 2'b00; req_addr_i = {2'd0, 2'd2};
    #1;
    check_val("rd_yumi", req_yumi_o, 2'b01);
    check_val("rd_mem_v", mem_v_o, 1'b1);
    check_val("rd_mem_w", mem_w_o, 1'b0);
    check_val("rd_mem_addr", mem_addr_o, 2'd2);
    tick();
    req_v_i = 2'b00;
    #1;
    check_val("rd_n1_resp_v", resp_v_o, 1'b0);
    check_val("rd_n1_busy", busy_o, 1'b1);
    tick();
    check_val("rd_resp_v", resp_v_o, 1'b1);
    check_val("rd_resp_data", resp_data_o, 32'hDEADBEEF);
    check_val("rd_resp_id", resp_dest_id_o, 1'b0);
    resp_yumi_i = 1'b1;
    tick();
    resp_yumi_i = 1'b0;
    #1;
    check_val("rd_idle_busy", busy_o, 1'b0);
    check_val("rd_idle_resp_v", resp_v_o, 1'b0);

    // Port 1 writes addr 3, then reads it back
    req_v_i = 2'b10; req_w_i = 2'b10; req_addr_i = {2'd3, 2'd0};
    req_data_i = {32'h12345678, 32'h0};
    #1;
    check_val("wr_yumi", req_yumi_o, 2'b10);
    check_val("wr_mem_w", mem_w_o, 1'b1);
    check_val("wr_mem_addr", mem_addr_o, 2'd3);
    check_val("wr_mem_data", mem_data_o, 32'h12345678);
    tick();
    req_w_i = 2'b00;
    #1;
`ifdef NOC_XBAR_MEM_SCHED_WRITE_ACK_EN
    check_val("wrack_resp_v", resp_v_o, 1'b1);
    check_val("wrack_data", resp_data_o, 32'h12345678);
    check_val("wrack_id", resp_dest_id_o, 1'b1);
    check_val("wrack_no_grant", req_yumi_o, 2'b00);
    resp_yumi_i = 1'b1;
    tick();
    resp_yumi_i = 1'b0;
    #1;
`else
    check_val("wr_no_resp", resp_v_o, 1'b0);
    check_val("wr_not_busy", busy_o, 1'b0);
`endif
    check_val("rb_yumi", req_yumi_o, 2'b10);
    check_val("rb_mem_w", mem_w_o, 1'b0);
    tick();
    req_v_i = 2'b00;
    tick();
    check_val("rb_resp_v", resp_v_o, 1'b1);
    check_val("rb_resp_data", resp_data_o, 32'h12345678);
    check_val("rb_resp_id", resp_dest_id_o, 1'b1);
    resp_yumi_i = 1'b1;
    tick();
    resp_yumi_i = 1'b0;

    // Contention: both ports read continuously, grants alternate 0,1,0,1
    req_v_i = 2'b11; req_w_i = 2'b00; req_addr_i = {2'd3, 2'd2};
    for (int n = 0; n < 4; n++) begin
      logic [1:0]  exp_yumi;
      logic [31:0] exp_data;
      exp_yumi = (n % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = (n % 2 == 0) ? 32'hDEADBEEF : 32'h12345678;
      #1;
      check_val("ct_grant", req_yumi_o, exp_yumi);
      tick();
      check_val("ct_read_no_grant", req_yumi_o, 2'b00);
      tick();
      check_val("ct_resp_v", resp_v_o, 1'b1);
      check_val("ct_resp_id", resp_dest_id_o, (n % 2 == 0) ? 1'b0 : 1'b1);
      check_val("ct_resp_data", resp_data_o, exp_data);
      resp_yumi_i = 1'b1;
      #1;
      check_val("ct_yumi_cycle_no_grant", req_yumi_o, 2'b00);
      tick();
      resp_yumi_i = 1'b0;
    end

    // Backpressure: port 0 wins again, response held for 10 cycles
    #1;
    check_val("bp_grant", req_yumi_o, 2'b01);
    tick();
    tick();
    for (int n = 0; n < 10; n++) begin
      check_val("bp_resp_v", resp_v_o, 1'b1);
      check_val("bp_data", resp_data_o, 32'hDEADBEEF);
      check_val("bp_id", resp_dest_id_o, 1'b0);
      check_val("bp_no_grant", req_yumi_o, 2'b00);
      tick();
    end
    resp_yumi_i = 1'b1;
    tick();
    resp_yumi_i = 1'b0;

    // Reset while holding port 1's response
    req_v_i = 2'b10;
    #1;
    check_val("rr_grant", req_yumi_o, 2'b10);
    tick();
    tick();
    check_val("rr_resp_v", resp_v_o, 1'b1);
    req_v_i = 2'b11;
    #1;
    reset_n_i = 1'b0;
    #1;
    check_val("rr_async_resp_v", resp_v_o, 1'b0);
    check_val("rr_async_busy", busy_o, 1'b0);
    check_val("rr_async_yumi", req_yumi_o, 2'b00);
    check_val("rr_async_data", resp_data_o, 32'h0);
    tick();
    reset_n_i = 1'b1;
    #1;
    check_val("rr_first_grant", req_yumi_o, 2'b01);
    tick();
    req_v_i = 2'b00;
    tick();
    check_val("rr_resp_data", resp_data_o, 32'hDEADBEEF);
    check_val("rr_resp_id", resp_dest_id_o, 1'b0);
    resp_yumi_i = 1'b1;
    tick();
    resp_yumi_i = 1'b0;

`ifdef NOC_XBAR_MEM_SCHED_WRITE_ACK_EN
    // Acknowledged write by port 0
    req_v_i = 2'b01; req_w_i = 2'b01; req_addr_i = {2'd0, 2'd1};
    req_data_i = {32'h0, 32'hA5A5A5A5};
    #1;
    check_val("ack_grant", req_yumi_o, 2'b01);
    tick();
    req_v_i = 2'b00; req_w_i = 2'b00;
    #1;
    check_val("ack_resp_v", resp_v_o, 1'b1);
    check_val("ack_data", resp_data_o, 32'hA5A5A5A5);
    check_val("ack_id", resp_dest_id_o, 1'b0);
    resp_yumi_i = 1'b1;
    tick();
    resp_yumi_i = 1'b0;
    #1;
    check_val("ack_idle", busy_o, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
